// File: rtl/tri2d_div_udiv_17ns_5ns_14_seq.sv
// Radix-2 restoring unsigned divider, 17-bit dividend by 5-bit divisor.
// Fixed 17-cycle latency, saturating 14-bit quotient, start/done handshake.
module tri2d_div_udiv_17ns_5ns_14_seq #(
  parameter int unsigned ID         = 32'd1,
  parameter int unsigned din0_WIDTH = 32'd17,
  parameter int unsigned din1_WIDTH = 32'd5,
  parameter int unsigned dout_WIDTH = 32'd14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dz
);

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [16:0] dvd_q, dvd_d;
  logic [4:0]  dvs_q, dvs_d;
  logic [5:0]  prem_q, prem_d;
  logic        done_q, done_d;
  logic [13:0] quot_q, quot_d;
  logic [4:0]  rem_q, rem_d;
  logic        ovf_q, ovf_d;
  logic        dz_q, dz_d;

  logic [6:0]  shifted;
  logic [6:0]  trial;
  logic        qbit;
  logic [5:0]  prem_next;
  logic [16:0] q_full;
  logic        q_big;

  // Partial remainder stays below the divisor, so a 7-bit difference never wraps;
  // bit 6 is the borrow.
  assign shifted   = {prem_q, dvd_q[16]};
  assign trial     = shifted - {2'b00, dvs_q};
  assign qbit      = ~trial[6];
  assign prem_next = qbit ? trial[5:0] : shifted[5:0];
  assign q_full    = {dvd_q[15:0], qbit};
  assign q_big     = |q_full[16:14];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          dvd_d   = din0;
          dvs_d   = din1;
          prem_d  = '0;
          cnt_d   = 5'd17;
          state_d = StCalc;
        end
      end
      StCalc: begin
        prem_d = prem_next;
        dvd_d  = q_full;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = StIdle;
          done_d  = 1'b1;
          if (dvs_q == 5'd0) begin
            quot_d = 14'h3FFF;
            rem_d  = '0;
            ovf_d  = 1'b0;
            dz_d   = 1'b1;
          end else begin
            quot_d = q_big ? 14'h3FFF : q_full[13:0];
            rem_d  = prem_next[4:0];
            ovf_d  = q_big;
            dz_d   = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q == StCalc);
  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_tri2d_div_udiv_17ns_5ns_14_seq.sv
// Randomised and directed bench for the iterative 17/5 divider against an
// arithmetic reference model.
module tb_tri2d_div_udiv_17ns_5ns_14_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        start;
  logic [16:0] din0;
  logic [4:0]  din1;
  logic        busy;
  logic        done;
  logic [13:0] quot;
  logic [4:0]  rem;
  logic        ovf;
  logic        dz;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  tri2d_div_udiv_17ns_5ns_14_seq #(
    .ID        (32'd1),
    .din0_WIDTH(32'd17),
    .din1_WIDTH(32'd5),
    .dout_WIDTH(32'd14)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ce   (ce),
    .start(start),
    .din0 (din0),
    .din1 (din1),
    .busy (busy),
    .done (done),
    .quot (quot),
    .rem  (rem),
    .ovf  (ovf),
    .dz   (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with saturation and zero-divisor rules.
  task automatic check_result(input string tag, input int unsigned a, input int unsigned b);
    int unsigned eq, er, eo, ed;
    if (b == 0) begin
      eq = 16383; er = 0; eo = 0; ed = 1;
    end else begin
      eq = (a / b > 16383) ? 16383 : a / b;
      er = a % b;
      eo = (a / b > 16383) ? 1 : 0;
      ed = 0;
    end
    check({tag, ".quot"}, quot, eq);
    check({tag, ".rem"},  rem,  er);
    check({tag, ".ovf"},  ovf,  eo);
    check({tag, ".dz"},   dz,   ed);
  endtask

  task automatic launch(input int unsigned a, input int unsigned b);
    logic [16:0] a17;
    logic [4:0]  b5;
    a17 = a[16:0];
    b5  = b[4:0];
    @(negedge clk);
    din0  = a17;
    din1  = b5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  // Counts edges after the accept edge until done is seen; busy_n counts busy samples.
  task automatic wait_done(output int unsigned n, output int unsigned busy_n);
    n = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
    end while (!done && n < 100);
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic run_op(input string tag, input int unsigned a, input int unsigned b);
    int unsigned n, bn;
    launch(a, b);
    wait_done(n, bn);
    check({tag, ".latency"}, n, 17);
    check({tag, ".busy_cycles"}, bn + 1, 17);
    check({tag, ".busy_at_done"}, busy, 0);
    check_result(tag, a, b);
  endtask

  initial begin
    int unsigned n, bn;
    bit saw_done;

    reset = 1'b0;
    ce    = 1'b1;
    start = 1'b1;
    din0  = 17'd17000;
    din1  = 5'd5;
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.quot", quot, 0);
    check("rst.rem",  rem,  0);
    check("rst.ovf",  ovf,  0);
    check("rst.dz",   dz,   0);
    repeat (3) @(negedge clk);
    check("rst.busy_held", busy, 0);

    // Release with start already high: first enabled edge accepts 17000/5.
    reset = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rel.busy", busy, 1);
    wait_done(n, bn);
    check("rel.latency", n, 17);
    check("rel.busy_cycles", bn + 1, 17);
    check_result("d17000_5", 17000, 5);

    run_op("d131071_31", 131071, 31);
    run_op("d131071_1", 131071, 1);
    run_op("d1234_0", 1234, 0);

    // Back-to-back: second start in the done cycle.
    run_op("b2b_a", 100, 7);
    din0  = 17'd99;
    din1  = 5'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b.done_drop", done, 0);
    check("b2b.busy", busy, 1);
    check("b2b.quot_hold", quot, 14);
    wait_done(n, bn);
    check("b2b_b.latency", n, 17);
    check_result("b2b_b", 99, 10);

    // Start pulse mid-calculation must be ignored.
    launch(60000, 7);
    repeat (4) @(negedge clk);
    din0  = 17'd5;
    din1  = 5'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, bn);
    check("ign.latency", n + 5, 17);
    check_result("ign", 60000, 7);
    @(negedge clk);
    check("ign.no_restart", busy, 0);

    // Clock-enable stall of 5 cycles during the calculation.
    launch(5000, 3);
    repeat (3) @(negedge clk);
    ce = 1'b0;
    repeat (5) @(negedge clk);
    ce = 1'b1;
    wait_done(n, bn);
    check("stall.latency", n + 8, 22);
    check_result("stall", 5000, 3);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall.done_held", done, 1);
    end
    ce = 1'b1;
    @(negedge clk);
    check("stall.done_drop", done, 0);

    // Asynchronous reset in the middle of the calculation.
    launch(50000, 3);
    repeat (7) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.quot", quot, 0);
    check("abort.rem",  rem,  0);
    check("abort.ovf",  ovf,  0);
    check("abort.dz",   dz,   0);
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort.no_done", saw_done, 0);
    run_op("d30_4", 30, 4);

    for (int i = 0; i < 40; i++) begin
      int unsigned a, b;
      a = (i % 3 == 0) ? $urandom_range(0, 511) : $urandom_range(0, 131071);
      b = $urandom_range(0, 31);
      run_op("rand", a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
